// File: rtl/wb_sdram_traffic_gen.sv
// Wishbone burst write/read-back traffic generator for the SDRAM controller WB slave.
// Optional TGEN_ERR_INJECT_EN adds inject_err to corrupt one write beat for compare-path self-test.
module wb_sdram_traffic_gen #(
  parameter int APP_AW    = 26,
  parameter int dw        = 32,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              sdr_init_done,
  input  logic [APP_AW-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_num_bursts,
  input  logic [3:0]        cfg_burst_len,
  input  logic [31:0]       cfg_seed,
`ifdef TGEN_ERR_INJECT_EN
  input  logic              inject_err,
`endif
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       err_count,
  output logic [APP_AW-1:0] err_addr
);

  localparam int          BW      = dw / 8;
  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  CTI_INC = 3'b010;
  localparam logic [2:0]  CTI_END = 3'b111;
  localparam logic [31:0] POLY    = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WR, S_GAP, S_RD, S_FIN} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  function automatic logic [dw-1:0] beat_data(input logic [31:0] v, input logic inv);
    return {(dw/32){v}} ^ {{(dw-1){1'b0}}, inv};
  endfunction

  state_t            r_state;
  logic [APP_AW-1:0] r_base;
  logic [15:0]       r_nbursts;
  logic [15:0]       r_burst;
  logic [3:0]        r_len;
  logic [3:0]        r_beat;
  logic [31:0]       r_seed;
  logic [31:0]       r_lfsr;
  logic [TW-1:0]     r_tmo;

  logic [3:0]        w_len_eff;
  logic [31:0]       w_lfsr_nx;
  logic [APP_AW-1:0] w_addr_nx;
  logic              w_last_beat;
  logic              w_rd_bad;
  logic              w_more;
  logic              w_inj;

  assign w_lfsr_nx   = lfsr_step(r_lfsr);
  assign w_addr_nx   = wb_addr_o + APP_AW'(BW);
  assign w_last_beat = (r_beat == r_len - 4'd1);
  assign w_rd_bad    = (wb_dat_i != beat_data(r_lfsr, 1'b0));
  assign w_more      = (r_burst != r_nbursts);
  assign wb_sel_o    = {BW{wb_cyc_o}};

  always_comb begin
    w_len_eff = cfg_burst_len;
    if (cfg_burst_len == 4'd0) begin
      w_len_eff = 4'd1;
    end else if (cfg_burst_len > 4'(MAX_BURST)) begin
      w_len_eff = 4'(MAX_BURST);
    end else begin
      w_len_eff = cfg_burst_len;
    end
  end

`ifdef TGEN_ERR_INJECT_EN
  // A write beat is loaded onto the bus this cycle; it consumes an armed injection.
  logic w_load_wr;
  logic r_inj_armed;
  assign w_load_wr = ((r_state == S_WAIT) && sdr_init_done && (r_nbursts != 16'd0)) ||
                     ((r_state == S_WR) && wb_ack_i && !w_last_beat) ||
                     ((r_state == S_GAP) && wb_we_o && w_more);
  assign w_inj = r_inj_armed;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_inj_armed <= 1'b0;
    end else begin
      r_inj_armed <= inject_err | (r_inj_armed & ~w_load_wr);
    end
  end
`else
  assign w_inj = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_nbursts <= 16'd0;
      r_burst   <= 16'd0;
      r_len     <= 4'd0;
      r_beat    <= 4'd0;
      r_seed    <= 32'd0;
      r_lfsr    <= 32'd0;
      r_tmo     <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_cti_o  <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= 16'd0;
      err_addr  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base    <= cfg_base_addr;
            r_nbursts <= cfg_num_bursts;
            r_len     <= w_len_eff;
            r_seed    <= cfg_seed;
            r_lfsr    <= cfg_seed;
            err       <= 1'b0;
            err_count <= 16'd0;
            err_addr  <= '0;
            busy      <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sdr_init_done) begin
            r_burst   <= 16'd0;
            r_beat    <= 4'd0;
            r_tmo     <= '0;
            wb_addr_o <= r_base;
            if (r_nbursts == 16'd0) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_FIN;
            end else begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_dat_o <= beat_data(r_lfsr, w_inj);
              wb_cti_o <= (r_len == 4'd1) ? CTI_END : CTI_INC;
              r_state  <= S_WR;
            end
          end
        end
        S_WR, S_RD: begin
          if (wb_ack_i) begin
            r_tmo     <= '0;
            r_lfsr    <= w_lfsr_nx;
            wb_addr_o <= w_addr_nx;
            if ((r_state == S_RD) && w_rd_bad) begin
              err <= 1'b1;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              if (err_count == 16'd0) err_addr <= wb_addr_o;
            end
            if (w_last_beat) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              r_beat   <= 4'd0;
              r_burst  <= r_burst + 16'd1;
              if ((r_state == S_RD) && (r_burst + 16'd1 == r_nbursts)) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_FIN;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              r_beat   <= r_beat + 4'd1;
              wb_dat_o <= beat_data(w_lfsr_nx, w_inj & wb_we_o);
              wb_cti_o <= (r_beat + 4'd2 == r_len) ? CTI_END : CTI_INC;
            end
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err      <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_FIN;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_GAP: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          r_tmo    <= '0;
          wb_cti_o <= (r_len == 4'd1) ? CTI_END : CTI_INC;
          // Write pass finished: replay the same region and pattern for read-back.
          if (wb_we_o && !w_more) begin
            wb_we_o   <= 1'b0;
            wb_addr_o <= r_base;
            r_lfsr    <= r_seed;
            r_burst   <= 16'd0;
            wb_dat_o  <= beat_data(r_seed, 1'b0);
            r_state   <= S_RD;
          end else begin
            wb_dat_o <= beat_data(r_lfsr, w_inj & wb_we_o);
            r_state  <= wb_we_o ? S_WR : S_RD;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_traffic_gen.sv
// Scoreboard bench for wb_sdram_traffic_gen: expected WB beats are queued by the stimulus
// and popped by a monitor on every acknowledged beat.
module tb_wb_sdram_traffic_gen;
  localparam int AW = 26;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          init_done = 1'b1;
  logic [AW-1:0] cfg_base = '0;
  logic [15:0]   cfg_nb = 16'd0;
  logic [3:0]    cfg_len = 4'd0;
  logic [31:0]   cfg_seed = 32'd1;
`ifdef TGEN_ERR_INJECT_EN
  logic          inject_err = 1'b0;
`endif
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i = 1'b0;
  logic [DW-1:0] wb_dat_i = '0;
  logic          busy, done, err;
  logic [15:0]   err_count;
  logic [AW-1:0] err_addr;

  always #5 clk = ~clk;

  wb_sdram_traffic_gen #(.APP_AW(AW), .dw(DW), .MAX_BURST(8), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .sdr_init_done(init_done),
    .cfg_base_addr(cfg_base), .cfg_num_bursts(cfg_nb), .cfg_burst_len(cfg_len), .cfg_seed(cfg_seed),
`ifdef TGEN_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
    .wb_dat_i(wb_dat_i), .busy(busy), .done(done), .err(err), .err_count(err_count),
    .err_addr(err_addr)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [2:0]    cti;
  } beat_t;

  beat_t         exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic          ack_en = 1'b1;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [31:0]   mem [logic [AW-1:0]];
  logic [31:0]   tbl [8] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001,
                              32'hB02C_0003, 32'hD836_0002, 32'h6C1B_0001, 32'hB62D_8003};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    logic [31:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  // Zero-wait slave with backing memory; optionally corrupts one read address.
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && ack_en) begin
      wb_ack_i = 1'b1;
      if (wb_we_o) begin
        mem[wb_addr_o] = wb_dat_o;
      end else begin
        wb_dat_i = mem.exists(wb_addr_o) ? mem[wb_addr_o] : 32'h0;
        if (corrupt_en && wb_addr_o == corrupt_addr) wb_dat_i = wb_dat_i ^ 32'h0000_0010;
      end
    end else begin
      wb_ack_i = 1'b0;
    end
  end

  // Monitor: every acknowledged beat must match the head of the expectation queue.
  always @(negedge clk) begin
    beat_t e;
    #1;
    if (!rst && wb_cyc_o && wb_stb_o && wb_ack_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {32'h0, 6'h0, wb_addr_o}, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {wb_we_o, wb_cti_o, wb_addr_o, (wb_we_o ? wb_dat_o : 32'h0)},
                    {e.we, e.cti, e.addr, (e.we ? e.data : 32'h0)});
      end
    end
  end

  task automatic push_run(input logic [AW-1:0] base, input int nb, input int len,
                          input logic [31:0] seed, input logic inj);
    int eff;
    beat_t e;
    logic [31:0] l;
    logic [AW-1:0] a;
    logic first;
    eff = (len == 0) ? 1 : ((len > 8) ? 8 : len);
    for (int p = 0; p < 2; p++) begin
      l = seed;
      a = base;
      first = (p == 0) ? inj : 1'b0;
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < eff; k++) begin
          e.we = (p == 0);
          e.addr = a;
          e.data = l ^ {31'h0, first};
          e.cti = (k == eff - 1) ? 3'b111 : 3'b010;
          exp_q.push_back(e);
          first = 1'b0;
          a = a + 26'd4;
          l = lfsr_next(l);
        end
      end
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input logic [15:0] nb,
                             input logic [3:0] len, input logic [31:0] seed);
    @(negedge clk);
    cfg_base = base;
    cfg_nb = nb;
    cfg_len = len;
    cfg_seed = seed;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int cyc_n);
    int n;
    n = 0;
    cyc_n = 0;
    while (!done && n < 3000) begin
      if (wb_cyc_o) cyc_n++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, {63'h0, done}, 64'h1);
    chk({nm, "_busy_at_done"}, {63'h0, busy}, 64'h0);
    @(negedge clk);
    chk({nm, "_done_1cyc"}, {63'h0, done}, 64'h0);
    chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'h0);
    exp_q.delete();
  endtask

  task automatic chk_result(input string nm, input logic e_err, input logic [15:0] e_cnt,
                            input logic [AW-1:0] e_addr);
    chk({nm, "_err"}, {63'h0, err}, {63'h0, e_err});
    chk({nm, "_err_count"}, {48'h0, err_count}, {48'h0, e_cnt});
    if (e_cnt != 16'd0) chk({nm, "_err_addr"}, {38'h0, err_addr}, {38'h0, e_addr});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctrl"}, {51'h0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, busy, done, err}, 64'h0);
    chk({nm, "_addr_dat"}, {6'h0, wb_addr_o, wb_dat_o}, 64'h0);
    chk({nm, "_errinfo"}, {22'h0, err_count, err_addr}, 64'h0);
  endtask

  initial begin
    beat_t e;
    int cyc_n;
    int n;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Hand-computed vectors: base 0x100, 2 bursts of 4, seed 1.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        e.we = (p == 0);
        e.addr = 26'h100 + 26'(4 * i);
        e.data = tbl[i];
        e.cti = (i % 4 == 3) ? 3'b111 : 3'b010;
        exp_q.push_back(e);
      end
    end
    pulse_start(26'h100, 16'd2, 4'd4, 32'd1);
    wait_done("basic", cyc_n);
    chk_result("basic", 1'b0, 16'd0, '0);

    // Corrupted read at 0x108, plus a start while busy that must be ignored.
    corrupt_en = 1'b1;
    corrupt_addr = 26'h108;
    push_run(26'h100, 2, 4, 32'd3, 1'b0);
    pulse_start(26'h100, 16'd2, 4'd4, 32'd3);
    repeat (4) @(negedge clk);
    pulse_start(26'h0, 16'd1, 4'd1, 32'd99);
    wait_done("corrupt", cyc_n);
    chk_result("corrupt", 1'b1, 16'd1, 26'h108);
    corrupt_en = 1'b0;

    // Init gating: no bus cycle until the cycle after sdr_init_done rises.
    init_done = 1'b0;
    push_run(26'h2000, 1, 2, 32'h0000_ACE1, 1'b0);
    pulse_start(26'h2000, 16'd1, 4'd2, 32'h0000_ACE1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wb_cyc_o) n++;
    end
    chk("init_no_cyc", 64'(n), 64'h0);
    init_done = 1'b1;
    @(negedge clk);
    chk("init_cyc_next", {63'h0, wb_cyc_o}, 64'h1);
    wait_done("init", cyc_n);
    chk_result("init", 1'b0, 16'd0, '0);

    // Timeout: slave never acks, TIMEOUT = 16.
    ack_en = 1'b0;
    pulse_start(26'h200, 16'd1, 4'd2, 32'd7);
    wait_done("timeout", cyc_n);
    chk("timeout_cyc_cycles", 64'(cyc_n), 64'd16);
    chk_result("timeout", 1'b1, 16'd0, '0);
    ack_en = 1'b1;

    // Burst length 0 -> 1-beat bursts.
    push_run(26'h300, 3, 0, 32'h0000_1234, 1'b0);
    pulse_start(26'h300, 16'd3, 4'd0, 32'h0000_1234);
    wait_done("len0", cyc_n);
    chk_result("len0", 1'b0, 16'd0, '0);

    // Burst length 15 -> clamped to 8 beats.
    push_run(26'h3FF_FFF0, 1, 15, 32'hDEAD_BEEF, 1'b0);
    pulse_start(26'h3FF_FFF0, 16'd1, 4'd15, 32'hDEAD_BEEF);
    wait_done("len15_wrap", cyc_n);
    chk_result("len15_wrap", 1'b0, 16'd0, '0);

    // Zero bursts: done with no bus activity.
    pulse_start(26'h400, 16'd0, 4'd4, 32'd5);
    wait_done("zero_bursts", cyc_n);
    chk("zero_bursts_no_cyc", 64'(cyc_n), 64'h0);
    chk_result("zero_bursts", 1'b0, 16'd0, '0);

    // Reset in the middle of a read burst after an error has been recorded.
    corrupt_en = 1'b1;
    corrupt_addr = 26'h400;
    push_run(26'h400, 2, 4, 32'd9, 1'b0);
    pulse_start(26'h400, 16'd2, 4'd4, 32'd9);
    n = 0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_err_seen", {63'h0, err}, 64'h1);
    chk("midrst_in_burst", {62'h0, wb_cyc_o, wb_we_o}, 64'h2);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    corrupt_en = 1'b0;
    push_run(26'h400, 2, 4, 32'd9, 1'b0);
    pulse_start(26'h400, 16'd2, 4'd4, 32'd9);
    wait_done("after_rst", cyc_n);
    chk_result("after_rst", 1'b0, 16'd0, '0);

`ifdef TGEN_ERR_INJECT_EN
    @(negedge clk);
    inject_err = 1'b1;
    @(negedge clk);
    inject_err = 1'b0;
    push_run(26'h500, 1, 4, 32'h0000_0055, 1'b1);
    pulse_start(26'h500, 16'd1, 4'd4, 32'h0000_0055);
    wait_done("inject", cyc_n);
    chk_result("inject", 1'b1, 16'd1, 26'h500);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
